// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits MSB first, stop bit, sampled at mid-bit.
// Optional even-parity bit between data and stop is enabled with `define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 fpga_clk,
    input  logic                 nrst,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                state_reg, state_next;
    logic [1:0]            sync_reg;
    logic                  sin_d_reg;
    logic                  sin_s;
    logic [TICK_W-1:0]     tick_cnt_reg, tick_cnt_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]  shreg_reg, shreg_next;
    logic [DATA_BITS-1:0]  dout_reg, dout_next;
    logic                  rx_valid_reg, rx_valid_next;
    logic                  frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_reg, par_bad_next;
    logic                  parity_err_reg, parity_err_next;
`endif

    assign sin_s = sync_reg[1];

    // Synchroniser and edge-detect history reset high so a reset never fakes a start edge.
    always_ff @(posedge fpga_clk) begin
        if (!nrst) begin
            sync_reg  <= 2'b11;
            sin_d_reg <= 1'b1;
        end else begin
            sync_reg  <= {sync_reg[0], sin};
            sin_d_reg <= sin_s;
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shreg_reg      <= '0;
            dout_reg       <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shreg_reg      <= shreg_next;
            dout_reg       <= dout_next;
            rx_valid_reg   <= rx_valid_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg    <= par_bad_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shreg_next      = shreg_reg;
        dout_next       = dout_reg;
        rx_valid_next   = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next    = par_bad_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (sin_d_reg && !sin_s) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end
            START: begin
                if (tick_cnt_reg == TICK_MID) begin
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = sin_s ? IDLE : DATA;
                end else begin
                    tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_cnt_reg == TICK_LAST) begin
                    shreg_next    = {shreg_reg[DATA_BITS-2:0], sin_s};
                    tick_cnt_next = '0;
                    bit_cnt_next  = bit_cnt_reg + BIT_W'(1);
                    if (bit_cnt_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                // Even parity: data plus parity bit must hold an even number of ones.
                if (tick_cnt_reg == TICK_LAST) begin
                    par_bad_next  = ^{shreg_reg, sin_s};
                    tick_cnt_next = '0;
                    state_next    = STOP;
                end else begin
                    tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                end
            end
`endif
            STOP: begin
                if (tick_cnt_reg == TICK_LAST) begin
                    tick_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_next = par_bad_reg;
`endif
                    if (sin_s) begin
                        dout_next     = shreg_reg;
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end else begin
                    tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                end
            end
            BREAK: begin
                // Held-low line: wait for it to return high so only one frame_err is raised.
                if (sin_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout      = dout_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: reset, single frames, back-to-back, glitch, framing error, mid-frame reset.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       fpga_clk;
    logic       nrst;
    logic       sin;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .fpga_clk (fpga_clk),
        .nrst     (nrst),
        .sin      (sin),
        .dout     (dout),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    int cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    // Monitor counters only ever grow; scenarios compare deltas against snapshots.
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         busy_cnt = 0;
    int         perr_cnt = 0;
    int         perr_valid_cnt = 0;
    int         valid_cyc = 0;
    logic [7:0] got[$];

    always @(negedge fpga_clk) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            got.push_back(dout);
            $display("[%0t] rx byte 0x%02h", $time, dout);
        end
        if (frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            $display("[%0t] frame error, dout 0x%02h", $time, dout);
        end
        if (rx_valid && frame_err) both_cnt = both_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            perr_cnt = perr_cnt + 1;
            if (rx_valid) perr_valid_cnt = perr_valid_cnt + 1;
        end
`endif
    end

    int fall_cyc = 0;

    // Called at a negedge; drives each bit for CPB cycles and returns at a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        sin = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge fpga_clk);
        for (int i = 7; i >= 0; i--) begin
            sin = d[i];
            repeat (CPB) @(negedge fpga_clk);
        end
`ifdef UART_RX_PARITY_EN
        sin = par_bit;
        repeat (CPB) @(negedge fpga_clk);
`else
        if (par_bit === 1'bx) $display("parity bit unknown");
`endif
        sin = stop_bit;
        repeat (CPB) @(negedge fpga_clk);
        $display("[%0t] sent byte 0x%02h stop %0b", $time, d, stop_bit);
    endtask

    task automatic test_reset();
        int v0, f0, b0;
        sin  = 1'b1;
        nrst = 1'b0;
        repeat (4) @(negedge fpga_clk);
        nrst = 1'b1;
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        repeat (500) @(negedge fpga_clk);
        total_cnt++;
        if (dout !== 8'h00) $display("FAIL reset_dout: got 0x%02h expected 0x00", dout);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL reset_no_valid: got %0d expected 0", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (ferr_cnt - f0 !== 0) $display("FAIL reset_no_ferr: got %0d expected 0", ferr_cnt - f0);
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt - b0 !== 0) $display("FAIL reset_idle_busy: got %0d busy cycles expected 0", busy_cnt - b0);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int v0, lat;
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        repeat (20) @(negedge fpga_clk);
        lat = valid_cyc - fall_cyc;
        total_cnt++;
        if (valid_cnt - v0 !== 1) $display("FAIL single_count: got %0d expected 1", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (got[v0] !== 8'hA5) $display("FAIL single_strobe_data: got 0x%02h expected 0xa5", got[v0]);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 8'hA5) $display("FAIL single_dout_held: got 0x%02h expected 0xa5", dout);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL single_busy: got %0b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
`ifdef UART_RX_PARITY_EN
        if (lat < 169 || lat > 171) $display("FAIL single_latency: got %0d expected 169..171", lat);
`else
        if (lat < 153 || lat > 155) $display("FAIL single_latency: got %0d expected 153..155", lat);
`endif
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        repeat (20) @(negedge fpga_clk);
        total_cnt++;
        if (valid_cnt - v0 !== 3) $display("FAIL b2b_count: got %0d expected 3", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (got[v0] !== 8'h00) $display("FAIL b2b_byte0: got 0x%02h expected 0x00", got[v0]);
        else pass_cnt++;
        total_cnt++;
        if (got[v0+1] !== 8'hFF) $display("FAIL b2b_byte1: got 0x%02h expected 0xff", got[v0+1]);
        else pass_cnt++;
        total_cnt++;
        if (got[v0+2] !== 8'h3C) $display("FAIL b2b_byte2: got 0x%02h expected 0x3c", got[v0+2]);
        else pass_cnt++;
        total_cnt++;
        if (ferr_cnt - f0 !== 0) $display("FAIL b2b_no_ferr: got %0d expected 0", ferr_cnt - f0);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int v0, f0, b0;
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        sin = 1'b0;
        repeat (4) @(negedge fpga_clk);
        sin = 1'b1;
        repeat (40) @(negedge fpga_clk);
        $display("[%0t] glitch done, busy cycles %0d", $time, busy_cnt - b0);
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL glitch_no_valid: got %0d expected 0", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (ferr_cnt - f0 !== 0) $display("FAIL glitch_no_ferr: got %0d expected 0", ferr_cnt - f0);
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt - b0 <= 0) $display("FAIL glitch_busy_pulse: got %0d busy cycles expected >0", busy_cnt - b0);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %0b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, ^8'h55);
        repeat (100) @(negedge fpga_clk);
        sin = 1'b1;
        repeat (30) @(negedge fpga_clk);
        total_cnt++;
        if (ferr_cnt - f0 !== 1) $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL ferr_no_valid: got %0d expected 0", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 8'h3C) $display("FAIL ferr_dout_kept: got 0x%02h expected 0x3c", dout);
        else pass_cnt++;
        send_frame(8'h81, 1'b1, ^8'h81);
        repeat (20) @(negedge fpga_clk);
        total_cnt++;
        if (valid_cnt - v0 !== 1) $display("FAIL ferr_recover_count: got %0d expected 1", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 8'h81) $display("FAIL ferr_recover_dout: got 0x%02h expected 0x81", dout);
        else pass_cnt++;
        total_cnt++;
        if (both_cnt !== 0) $display("FAIL valid_ferr_exclusive: got %0d overlaps expected 0", both_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        logic [7:0] partial;
        v0 = valid_cnt; f0 = ferr_cnt;
        partial = 8'hC3;
        sin = 1'b0;
        repeat (CPB) @(negedge fpga_clk);
        for (int i = 7; i >= 5; i--) begin
            sin = partial[i];
            repeat (CPB) @(negedge fpga_clk);
        end
        sin  = 1'b1;
        nrst = 1'b0;
        repeat (2) @(negedge fpga_clk);
        nrst = 1'b1;
        total_cnt++;
        if (dout !== 8'h00) $display("FAIL midreset_dout_cleared: got 0x%02h expected 0x00", dout);
        else pass_cnt++;
        repeat (200) @(negedge fpga_clk);
        send_frame(8'h18, 1'b1, ^8'h18);
        repeat (20) @(negedge fpga_clk);
        total_cnt++;
        if (valid_cnt - v0 !== 1) $display("FAIL midreset_count: got %0d expected 1", valid_cnt - v0);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 8'h18) $display("FAIL midreset_dout: got 0x%02h expected 0x18", dout);
        else pass_cnt++;
        total_cnt++;
        if (ferr_cnt - f0 !== 0) $display("FAIL midreset_no_ferr: got %0d expected 0", ferr_cnt - f0);
        else pass_cnt++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, p0, pv0;
        v0 = valid_cnt; p0 = perr_cnt; pv0 = perr_valid_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (20) @(negedge fpga_clk);
        total_cnt++;
        if (perr_cnt - p0 !== 1) $display("FAIL parity_bad_err: got %0d expected 1", perr_cnt - p0);
        else pass_cnt++;
        total_cnt++;
        if (perr_valid_cnt - pv0 !== 1) $display("FAIL parity_with_valid: got %0d expected 1", perr_valid_cnt - pv0);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 8'h07) $display("FAIL parity_bad_dout: got 0x%02h expected 0x07", dout);
        else pass_cnt++;
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (20) @(negedge fpga_clk);
        total_cnt++;
        if (perr_cnt - p0 !== 0) $display("FAIL parity_good_err: got %0d expected 0", perr_cnt - p0);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 2) $display("FAIL parity_valid_count: got %0d expected 2", valid_cnt - v0);
        else pass_cnt++;
    endtask
`endif

    initial begin
        sin  = 1'b1;
        nrst = 1'b0;
        @(negedge fpga_clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
